// File: rtl/key_encoder_8_3.sv
// rtl/key_encoder_8_3.sv - debounced 8-to-3 priority key encoder with press/release filtering
// Optional multi-key detect is enabled by defining KEY_ENC_MULTI_DET_EN.
module key_encoder_8_3 #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_n,
    output logic [2:0] code,
    output logic       valid,
    output logic       active,
    output logic       multi
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      s1_q, s1_d;
    logic [7:0]      s2_q, s2_d;
    logic [7:0]      p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            active_q, active_d;
    logic [2:0]      enc_code;

    // Later (higher) indices overwrite earlier ones, so the highest low line wins.
    always_comb begin
        enc_code = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (!p_q[i]) begin
                enc_code = 3'(i);
            end
        end
    end

`ifdef KEY_ENC_MULTI_DET_EN
    logic       multi_q, multi_d;
    logic [3:0] zero_cnt;
    logic       enc_multi;

    always_comb begin
        zero_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            zero_cnt = zero_cnt + {3'b000, ~p_q[i]};
        end
        enc_multi = (zero_cnt > 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign multi = multi_q;
`else
    assign multi = 1'b0;
`endif

    always_comb begin
        s1_d     = key_n;
        s2_d     = s1_q;
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        valid_d  = 1'b0;
        active_d = active_q;
`ifdef KEY_ENC_MULTI_DET_EN
        multi_d  = multi_q;
`endif
        case (state_q)
            IDLE: begin
                if (s2_q != 8'hFF) begin
                    p_d     = s2_q;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (s2_q != p_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    code_d   = enc_code;
`ifdef KEY_ENC_MULTI_DET_EN
                    multi_d  = enc_multi;
`endif
                    valid_d  = 1'b1;
                    active_d = 1'b1;
                    state_d  = HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                // Pattern changes while held are deliberately ignored; only full release counts.
                if (s2_q == 8'hFF) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end
            end
            DEB_REL: begin
                if (s2_q != 8'hFF) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s1_q     <= 8'hFF;
            s2_q     <= 8'hFF;
            p_q      <= 8'hFF;
            cnt_q    <= '0;
            code_q   <= 3'b000;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end

    assign code   = code_q;
    assign valid  = valid_q;
    assign active = active_q;

endmodule

// File: doc/key_encoder_8_3.md
KEY_ENCODER_8_3 -- requirements
Module: key_encoder_8_3

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk and rst are sampled on the rising edge of clk only.
REQ-002 The block SHALL expose parameter DEB_CYCLES, default 16, minimum 2: the number of consecutive stable samples needed to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-005 The block SHALL have port key_n, input, 8 bits: asynchronous key lines, active low, idle value 8'hFF.
REQ-006 The block SHALL have port code, output, 3 bits: encoded index of the accepted key.
REQ-007 The block SHALL have port valid, output, 1 bit: one-cycle strobe marking a newly accepted press.
REQ-008 The block SHALL have port active, output, 1 bit: high while an accepted press is held.
REQ-009 The block SHALL have port multi, output, 1 bit: more than one line was low in the accepted pattern.

Function
REQ-010 key_n SHALL pass through a two-flop synchronizer; its second-stage output s is the only key value that internal logic uses.
REQ-011 The FSM SHALL have exactly four states: IDLE, DEB_PRESS, HELD and DEB_REL.
REQ-012 In IDLE, when s != 8'hFF, the block SHALL latch pattern p <= s, clear the counter and go to DEB_PRESS; otherwise it stays in IDLE.
REQ-013 In DEB_PRESS, when s != p, the block SHALL return to IDLE with no output change (bounce rejected).
REQ-014 In DEB_PRESS, when s == p, the counter SHALL increment.
REQ-015 On the edge where s == p and the counter equals DEB_CYCLES-1, the block SHALL register code, multi, valid=1 and active=1, then go to HELD.
REQ-016 Encoding SHALL be priority encoding with the highest index winning: code = the largest i with p[i]=0 (8'b1111_1110 -> 3'b000; 8'b0111_1111 -> 3'b111).
REQ-017 multi SHALL be 1 when two or more bits of p are 0.
REQ-018 valid SHALL be high for exactly one clock per accepted press.
REQ-019 Latency: with key_n stable, valid SHALL be high after rising edge DEB_CYCLES+3, counting from the first edge that samples the new key_n.
REQ-020 In HELD, any s != 8'hFF SHALL be ignored, including pattern changes; code and multi hold and no new valid is issued.
REQ-021 In HELD, when s == 8'hFF, the block SHALL clear the counter and go to DEB_REL.
REQ-022 In DEB_REL, when s != 8'hFF, the block SHALL return to HELD with active still 1.
REQ-023 In DEB_REL, when s == 8'hFF and the counter equals DEB_CYCLES-1, the block SHALL set active=0 and go to IDLE.
REQ-024 code and multi SHALL hold their last accepted values after release until the next accepted press.
REQ-025 The counter width SHALL be $clog2(DEB_CYCLES), and the counter SHALL never wrap, because every state exits at DEB_CYCLES-1.

Reset
REQ-026 While rst=1, the block SHALL set state=IDLE, code=3'b000, valid=0, active=0, multi=0, counter=0, both synchronizer stages=8'hFF and p=8'hFF.
REQ-027 A reset asserted mid-debounce or in HELD SHALL abort the operation without issuing valid.
REQ-028 After rst deasserts, a key already held SHALL be accepted as a new press after the normal latency.

Configuration
REQ-029 With macro KEY_ENC_MULTI_DET_EN defined, multi SHALL behave as specified in REQ-017.
REQ-030 Without KEY_ENC_MULTI_DET_EN, multi SHALL be constant 0 and its logic SHALL be absent; all other behaviour is unchanged.

Verification (bench uses DEB_CYCLES=4)
REQ-031 Single key: rst then key_n=8'hFB held -> valid one cycle after edge 7, code=3'b010, active=1, multi=0.
REQ-032 Bounce: key_n=8'hF7 for 2 cycles, then 8'hFF, then 8'hF7 held -> exactly one valid, code=3'b011, with timing measured from the last transition.
REQ-033 Priority: key_n=8'h5E -> code=3'b111, multi=1 with the macro defined; multi=0 without it.
REQ-034 Release: hold 8'hEF to acceptance, then 8'hFF for 2 cycles, then 8'hEF, then 8'hFF held -> active stays 1 through the glitch and falls 7 edges after the final release; no second valid.
REQ-035 Reset mid-debounce: key_n=8'hBF with rst pulsed at edge 5 -> no valid before reset; after reset, valid with code=3'b110 after 7 edges.
REQ-036 Sweep: every one-cold pattern pressed and released in turn -> code=i for each 8'hFF^(1<<i), one valid per press.
